// File: rtl/bram_nr1w_clr.sv
`default_nettype none
// ============================================================================
// Module   : bram_nr1w_clr
// Purpose  : N-read / 1-write block RAM built from NUM_READ replicated 1R1W
//            banks that share one write port. After reset, a sequencer
//            zeroes every entry before user traffic is accepted. Each read
//            port has its own valid flag. With BRAM_NR1W_PARITY_EN defined,
//            each word also stores an even-parity bit, and every port reports
//            a parity mismatch on the word it returns.
// Macro    : BRAM_NR1W_PARITY_EN (optional parity protection)
// Revision : 1.0 - initial release
// ============================================================================
module bram_nr1w_clr #(
   parameter int ADDR_WIDTH     = 4,
   parameter int DATA_WIDTH     = 8,
   parameter int NUM_READ       = 2,
   parameter int READ_BYPASS    = 0,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                             clk,
   input  logic                             rst_n,
   output logic                             init_done,
   input  logic                             wr_en,
   input  logic [ADDR_WIDTH-1:0]            wr_addr,
   input  logic [DATA_WIDTH-1:0]            wr_data,
   input  logic [NUM_READ-1:0]              rd_en,
   input  logic [NUM_READ*ADDR_WIDTH-1:0]   rd_addr,
   output logic [NUM_READ*DATA_WIDTH-1:0]   rd_data,
   output logic [NUM_READ-1:0]              rd_valid,
   output logic [NUM_READ-1:0]              parity_err
);

   localparam int DEPTH = 2**ADDR_WIDTH;
`ifdef BRAM_NR1W_PARITY_EN
   localparam int BANK_WIDTH = DATA_WIDTH + 1;
`else
   localparam int BANK_WIDTH = DATA_WIDTH;
`endif
   // The counter is one bit wider than the address so the terminal compare
   // is explicit and the counter can never wrap into a second pass.
   localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH+1)'(DEPTH - 1);

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH:0]     clr_cnt_q, clr_cnt_d;
   logic                    init_done_q, init_done_d;

   // Shared write port seen by every bank (clear writes or user writes).
   logic                    bank_we;
   logic [ADDR_WIDTH-1:0]   bank_addr;
   logic [BANK_WIDTH-1:0]   bank_wdata;
   logic [BANK_WIDTH-1:0]   user_word;
   logic                    rd_accept;

`ifdef BRAM_NR1W_PARITY_EN
   assign user_word = {^wr_data, wr_data};
`else
   assign user_word = wr_data;
`endif

   // Reads are only accepted once the clear sequence has finished.
   assign rd_accept = (state_q == ST_READY);
   assign init_done = init_done_q;

   // Next-state logic: clear sequencer and shared write-port selection.
   always_comb begin
      state_d     = state_q;
      clr_cnt_d   = clr_cnt_q;
      init_done_d = init_done_q;
      bank_we     = 1'b0;
      bank_addr   = wr_addr;
      bank_wdata  = user_word;
      case (state_q)
         ST_CLEAR: begin
            // User writes are dropped; the zero word has parity 0.
            bank_we    = rst_n;
            bank_addr  = clr_cnt_q[ADDR_WIDTH-1:0];
            bank_wdata = '0;
            clr_cnt_d  = clr_cnt_q + 1'b1;
            if (clr_cnt_q == LAST_ADDR) begin
               state_d     = ST_READY;
               init_done_d = 1'b1;
            end
         end
         ST_READY: begin
            init_done_d = 1'b1;
            bank_we     = wr_en & rst_n;
         end
         default: begin
            state_d = ST_READY;
         end
      endcase
   end

   // Control registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
         clr_cnt_q   <= '0;
         init_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         clr_cnt_q   <= clr_cnt_d;
         init_done_q <= init_done_d;
      end
   end

   for (genvar gi = 0; gi < NUM_READ; gi++) begin : g_bank
      logic [BANK_WIDTH-1:0]  mem_q [DEPTH];
      logic [ADDR_WIDTH-1:0]  raddr;
      logic [BANK_WIDTH-1:0]  rword;
      logic [DATA_WIDTH-1:0]  data_q, data_d;
      logic                   valid_q, valid_d;
      logic                   perr_d;

      assign raddr = rd_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];

      // Bank storage: every bank takes the same write so all ports agree.
      always_ff @(posedge clk) begin
         if (bank_we) begin
            mem_q[bank_addr] <= bank_wdata;
         end
      end

      // Read word selection, with optional forwarding of a same-cycle write.
      always_comb begin
         rword = mem_q[raddr];
         if ((READ_BYPASS != 0) && bank_we && (bank_addr == raddr)) begin
            rword = bank_wdata;
         end
      end

      // Per-port read result: capture on accept, otherwise hold data.
      always_comb begin
         data_d  = data_q;
         valid_d = 1'b0;
         perr_d  = 1'b0;
         if (rd_en[gi] && rd_accept) begin
            data_d  = rword[DATA_WIDTH-1:0];
            valid_d = 1'b1;
`ifdef BRAM_NR1W_PARITY_EN
            perr_d  = (^rword[DATA_WIDTH-1:0]) ^ rword[DATA_WIDTH];
`endif
         end
      end

      // Per-port output registers with synchronous active-low reset.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
         end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
         end
      end

`ifdef BRAM_NR1W_PARITY_EN
      logic perr_q;

      // Parity flag registered alongside valid; zero whenever valid is zero.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            perr_q <= 1'b0;
         end else begin
            perr_q <= perr_d;
         end
      end

      assign parity_err[gi] = perr_q;
`else
      logic perr_unused;
      assign perr_unused    = perr_d;
      assign parity_err[gi] = 1'b0;
`endif

      assign rd_data[gi*DATA_WIDTH +: DATA_WIDTH] = data_q;
      assign rd_valid[gi]                         = valid_q;
   end

endmodule
`default_nettype wire

// File: tb/tb_bram_nr1w_clr.sv
`default_nettype none
// ============================================================================
// Module   : tb_bram_nr1w_clr
// Purpose  : Self-checking bench for bram_nr1w_clr. Three instances share
//            the input stimulus: bypass off, bypass on, and clear disabled.
//            Both table-driven vectors and a random phase are compared
//            against a behavioural memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bram_nr1w_clr;

   localparam int AW    = 4;
   localparam int DW    = 8;
   localparam int NR    = 3;
   localparam int DEPTH = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst_n;
   logic              wr_en;
   logic [AW-1:0]     wr_addr;
   logic [DW-1:0]     wr_data;
   logic [NR-1:0]     rd_en;
   logic [NR*AW-1:0]  rd_addr;

   logic              init_done0, init_done1, init_done2;
   logic [NR*DW-1:0]  rd_data0, rd_data1, rd_data2;
   logic [NR-1:0]     rd_valid0, rd_valid1, rd_valid2;
   logic [NR-1:0]     parity_err0, parity_err1, parity_err2;

   bram_nr1w_clr #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_READ(NR),
                   .READ_BYPASS(0), .CLEAR_ON_RESET(1)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .init_done(init_done0),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0),
      .rd_valid(rd_valid0), .parity_err(parity_err0));

   bram_nr1w_clr #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_READ(NR),
                   .READ_BYPASS(1), .CLEAR_ON_RESET(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .init_done(init_done1),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1),
      .rd_valid(rd_valid1), .parity_err(parity_err1));

   bram_nr1w_clr #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_READ(NR),
                   .READ_BYPASS(0), .CLEAR_ON_RESET(0)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .init_done(init_done2),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data2),
      .rd_valid(rd_valid2), .parity_err(parity_err2));

   int n_vec = 0;
   int n_err = 0;

   // Reference model: plain memory plus expected registered outputs.
   logic [DW-1:0]    m_mem [DEPTH];
   logic [NR*DW-1:0] e_data0, e_data1;
   logic [NR-1:0]    e_valid;

   typedef struct {
      logic           we;
      logic [AW-1:0]  wa;
      logic [DW-1:0]  wd;
      logic [NR-1:0]  re;
      logic [NR*AW-1:0] ra;
      logic [NR*DW-1:0] x0;
      logic [NR*DW-1:0] x1;
      logic [NR-1:0]  xv;
   } vec_t;

   vec_t tbl [8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      for (int a = 0; a < DEPTH; a++) m_mem[a] = '0;
      e_data0 = '0;
      e_data1 = '0;
      e_valid = '0;
   endtask

   // Expected outputs after the coming edge, given the inputs now driven.
   task automatic model_step();
      for (int p = 0; p < NR; p++) begin
         logic [AW-1:0] a;
         a = rd_addr[p*AW +: AW];
         if (rd_en[p]) begin
            e_valid[p]            = 1'b1;
            e_data0[p*DW +: DW]   = m_mem[a];
            e_data1[p*DW +: DW]   = (wr_en && wr_addr == a) ? wr_data : m_mem[a];
         end else begin
            e_valid[p] = 1'b0;
         end
      end
      if (wr_en) m_mem[wr_addr] = wr_data;
   endtask

   task automatic check_outputs(input string tag);
      check({tag, "_valid0"}, rd_valid0, e_valid);
      check({tag, "_valid1"}, rd_valid1, e_valid);
      check({tag, "_data0"},  rd_data0,  e_data0);
      check({tag, "_data1"},  rd_data1,  e_data1);
      check({tag, "_perr0"},  parity_err0, 0);
      check({tag, "_perr1"},  parity_err1, 0);
   endtask

   task automatic idle_inputs();
      wr_en   = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      rd_en   = '0;
      rd_addr = '0;
   endtask

   // Waits for init_done on u_dut0 and returns the number of edges taken.
   task automatic wait_init(output int n, input logic chk_rdv);
      n = 0;
      while (n < 40) begin
         cycle();
         n++;
         if (chk_rdv) check("clear_rd_valid", rd_valid0 | rd_valid1, 0);
         if (init_done0) break;
      end
   endtask

   initial begin
      int n;
      // v0..v3 writes, v4/v5 multi-port read, v6/v7 read-during-write.
      tbl[0] = '{1'b1, 4'd2,  8'h11, 3'b000, 12'h000, 24'h000000, 24'h000000, 3'b000};
      tbl[1] = '{1'b1, 4'd7,  8'h22, 3'b000, 12'h000, 24'h000000, 24'h000000, 3'b000};
      tbl[2] = '{1'b1, 4'd15, 8'h33, 3'b000, 12'h000, 24'h000000, 24'h000000, 3'b000};
      tbl[3] = '{1'b1, 4'd3,  8'h44, 3'b000, 12'h000, 24'h000000, 24'h000000, 3'b000};
      tbl[4] = '{1'b0, 4'd0,  8'h00, 3'b111, 12'hF72, 24'h332211, 24'h332211, 3'b111};
      tbl[5] = '{1'b0, 4'd0,  8'h00, 3'b101, 12'hF72, 24'h332211, 24'h332211, 3'b101};
      tbl[6] = '{1'b1, 4'd3,  8'h55, 3'b111, 12'h333, 24'h444444, 24'h555555, 3'b111};
      tbl[7] = '{1'b0, 4'd0,  8'h00, 3'b111, 12'h333, 24'h555555, 24'h555555, 3'b111};

      rst_n = 1'b0;
      idle_inputs();
      repeat (3) cycle();
      check("rst_init_done0", init_done0, 0);
      check("rst_init_done2", init_done2, 0);
      check("rst_rd_valid",   rd_valid0, 0);
      check("rst_rd_data",    rd_data0, 0);
      check("rst_perr",       parity_err0, 0);

      // Clear with user writes and reads active; both must be ignored.
      wr_en   = 1'b1;
      wr_addr = 4'd5;
      wr_data = 8'hAA;
      rd_en   = 3'b111;
      rd_addr = 12'h555;
      rst_n   = 1'b1;
      cycle();
      check("noclr_init_done", init_done2, 1);
      check("clear_init_low", init_done0, 0);
      wait_init(n, 1'b1);
      check("clear_cycles", n + 1, 16);
      check("clear_init_done1", init_done1, 1);
      idle_inputs();
      model_reset();

      // Sweep every address on every port: all zero, including address 5.
      for (int a = 0; a < DEPTH; a++) begin
         rd_en   = 3'b111;
         rd_addr = {AW'(a), AW'(a), AW'(a)};
         model_step();
         cycle();
         check_outputs("sweep");
      end
      idle_inputs();
      model_step();
      cycle();
      check_outputs("sweep_end");

      // Directed vectors.
      for (int i = 0; i < 8; i++) begin
         wr_en   = tbl[i].we;
         wr_addr = tbl[i].wa;
         wr_data = tbl[i].wd;
         rd_en   = tbl[i].re;
         rd_addr = tbl[i].ra;
         model_step();
         cycle();
         check($sformatf("tbl%0d_valid0", i), rd_valid0, tbl[i].xv);
         check($sformatf("tbl%0d_valid1", i), rd_valid1, tbl[i].xv);
         check($sformatf("tbl%0d_data0", i),  rd_data0,  tbl[i].x0);
         check($sformatf("tbl%0d_data1", i),  rd_data1,  tbl[i].x1);
      end

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         wr_en   = 1'($urandom_range(0, 1));
         wr_addr = AW'($urandom_range(0, DEPTH-1));
         wr_data = DW'($urandom);
         rd_en   = NR'($urandom_range(0, 7));
         for (int p = 0; p < NR; p++) begin
            rd_addr[p*AW +: AW] = ($urandom_range(0, 3) == 0) ? wr_addr
                                                               : AW'($urandom_range(0, DEPTH-1));
         end
         model_step();
         cycle();
         check_outputs("rand");
      end
      idle_inputs();

`ifdef BRAM_NR1W_PARITY_EN
      // Corrupt one stored data bit in bank 2 and read it back there.
      wr_en   = 1'b1;
      wr_addr = 4'd4;
      wr_data = 8'h0F;
      cycle();
      idle_inputs();
      u_dut0.g_bank[2].mem_q[4][0] = ~u_dut0.g_bank[2].mem_q[4][0];
      rd_en   = 3'b100;
      rd_addr = 12'h400;
      cycle();
      check("parity_err", parity_err0, 3'b100);
      check("parity_valid2", rd_valid0[2], 1);
      check("parity_clean_bank", parity_err1, 0);
      idle_inputs();
`endif

      // Reset in the middle of a clear restarts the full sequence.
      rst_n = 1'b0;
      cycle();
      check("rst2_rd_data", rd_data0, 0);
      check("rst2_rd_valid", rd_valid0, 0);
      rst_n = 1'b1;
      repeat (9) cycle();
      rst_n = 1'b0;
      cycle();
      check("midclr_init_low", init_done0, 0);
      rst_n = 1'b1;
      wait_init(n, 1'b0);
      check("midclr_cycles", n, 16);
      model_reset();
      rd_en   = 3'b111;
      rd_addr = 12'h333;
      model_step();
      cycle();
      check_outputs("reclear");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
